// File: rtl/pong_pkg.sv
// Shared definitions for the Pong input path: button FSM states and default
// timing constants used by btn_conditioner, paddle_ctrl and the menu logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_e;

  localparam int CLK_HZ           = 100_000_000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int REPEAT_MS        = 500;
  localparam int REPEAT_PERIOD_MS = 100;

  localparam int CYCLES_PER_MS         = CLK_HZ / 1000;
  localparam int DEF_STABLE_CYCLES     = CYCLES_PER_MS * DEBOUNCE_MS;
  localparam int DEF_REPEAT_DELAY      = CYCLES_PER_MS * REPEAT_MS;
  localparam int DEF_REPEAT_PERIOD     = CYCLES_PER_MS * REPEAT_PERIOD_MS;

  // Counter width large enough for the biggest terminal count plus one spare bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_conditioner_tick_counter.sv
// Saturating up-counter with synchronous load and a "this tick reaches the
// terminal count" flag, shared by the debounce and auto-repeat timers.
module tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_inc;

  assign w_inc = r_cnt + W'(1);
  assign o_hit = i_en && (w_inc == i_term);

  // Load wins over count; counting stops at the terminal value so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != i_term)) begin
      r_cnt <= w_inc;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces a synchronized button level with hysteresis on both edges and
// produces a clean level, press/release pulses and an auto-repeat pulse train.
module btn_conditioner
  import pong_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_sync,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  btn_state_e r_state;
  btn_state_e w_state_next;

  logic r_level, r_press, r_release, r_repeat, r_rep_armed;
  logic w_level_next, w_press_next, w_release_next, w_repeat_next, w_rep_armed_next;

  logic             w_stb_load, w_stb_en, w_stb_hit;
  logic [CNT_W-1:0] w_stb_load_val;
  logic             w_rep_load, w_rep_en, w_rep_hit;
  logic [CNT_W-1:0] w_rep_term;

  // After the first repeat the counter measures the shorter period instead of the delay.
  assign w_rep_term = r_rep_armed ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);

  tick_counter #(.W(CNT_W)) u_stable_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_stb_load),
    .i_load_val (w_stb_load_val),
    .i_en       (w_stb_en),
    .i_term     (CNT_W'(STABLE_CYCLES)),
    .o_hit      (w_stb_hit)
  );

  tick_counter #(.W(CNT_W)) u_repeat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_rep_load),
    .i_load_val ('0),
    .i_en       (w_rep_en),
    .i_term     (w_rep_term),
    .o_hit      (w_rep_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
      r_rep_armed <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_level     <= w_level_next;
      r_press     <= w_press_next;
      r_release   <= w_release_next;
      r_repeat    <= w_repeat_next;
      r_rep_armed <= w_rep_armed_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_press_next     = 1'b0;
    w_release_next   = 1'b0;
    w_repeat_next    = 1'b0;
    w_rep_armed_next = r_rep_armed;
    w_stb_load       = 1'b0;
    w_stb_load_val   = '0;
    w_stb_en         = 1'b0;
    w_rep_load       = 1'b0;
    w_rep_en         = 1'b0;

    case (r_state)
      IDLE: begin
        if (btn_sync) begin
          if (STABLE_CYCLES == 1) begin
            w_state_next     = HELD;
            w_press_next     = 1'b1;
            w_rep_load       = 1'b1;
            w_rep_armed_next = 1'b0;
          end else begin
            w_state_next   = DEB_PRESS;
            w_stb_load     = 1'b1;
            w_stb_load_val = CNT_W'(1);
          end
        end
      end

      DEB_PRESS: begin
        if (btn_sync) begin
          w_stb_en = 1'b1;
          if (w_stb_hit) begin
            w_state_next     = HELD;
            w_press_next     = 1'b1;
            w_stb_load       = 1'b1;
            w_rep_load       = 1'b1;
            w_rep_armed_next = 1'b0;
          end
        end else begin
          w_state_next = IDLE;
          w_stb_load   = 1'b1;
        end
      end

      HELD: begin
        if (btn_sync) begin
          w_rep_en = (REPEAT_EN != 0);
          if (w_rep_hit) begin
            w_repeat_next    = 1'b1;
            w_rep_load       = 1'b1;
            w_rep_armed_next = 1'b1;
          end
        end else if (STABLE_CYCLES == 1) begin
          w_state_next   = IDLE;
          w_release_next = 1'b1;
        end else begin
          // Repeat counter is left untouched here so a bounce resumes where it paused.
          w_state_next   = DEB_RELEASE;
          w_stb_load     = 1'b1;
          w_stb_load_val = CNT_W'(1);
        end
      end

      DEB_RELEASE: begin
        if (!btn_sync) begin
          w_stb_en = 1'b1;
          if (w_stb_hit) begin
            w_state_next   = IDLE;
            w_release_next = 1'b1;
            w_stb_load     = 1'b1;
          end
        end else begin
          w_state_next = HELD;
          w_stb_load   = 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_level_next = (w_state_next == HELD) || (w_state_next == DEB_RELEASE);
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: stimulus pushes expected per-cycle outputs
// into a queue, a monitor pops and compares them after every clock edge.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_sync = 1'b0;

  logic lvl0, prs0, rel0, rep0;
  logic lvl1, prs1, rel1, rep1;

  typedef struct {
    logic lvl;
    logic prs;
    logic rel;
    logic rep;
    int   scen;
    int   idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .STABLE_CYCLES (4),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_sync      (btn_sync),
    .btn_level     (lvl0),
    .press_pulse   (prs0),
    .release_pulse (rel0),
    .repeat_pulse  (rep0)
  );

  btn_conditioner #(
    .STABLE_CYCLES (4),
    .REPEAT_EN     (0),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_sync      (btn_sync),
    .btn_level     (lvl1),
    .press_pulse   (prs1),
    .release_pulse (rel1),
    .repeat_pulse  (rep1)
  );

  task automatic check(input string name, input int sc, input int ix,
                       input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s scen=%0d idx=%0d: actual=%b required=%b", name, sc, ix, act, exp);
    end
  endtask

  // One character per clock: input level and the outputs expected after that edge.
  task automatic run(input int sc, input string stim, input string e_lvl,
                     input string e_prs, input string e_rel, input string e_rep);
    exp_t e;
    for (int i = 0; i < stim.len(); i++) begin
      btn_sync = (stim[i] == "1");
      e.lvl  = (e_lvl[i] == "1");
      e.prs  = (e_prs[i] == "1");
      e.rel  = (e_rel[i] == "1");
      e.rep  = (e_rep[i] == "1");
      e.scen = sc;
      e.idx  = i;
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      check("btn_level",         mon_e.scen, mon_e.idx, lvl0, mon_e.lvl);
      check("press_pulse",       mon_e.scen, mon_e.idx, prs0, mon_e.prs);
      check("release_pulse",     mon_e.scen, mon_e.idx, rel0, mon_e.rel);
      check("repeat_pulse",      mon_e.scen, mon_e.idx, rep0, mon_e.rep);
      check("norep_btn_level",   mon_e.scen, mon_e.idx, lvl1, mon_e.lvl);
      check("norep_press",       mon_e.scen, mon_e.idx, prs1, mon_e.prs);
      check("norep_release",     mon_e.scen, mon_e.idx, rel1, mon_e.rel);
      check("norep_repeat",      mon_e.scen, mon_e.idx, rep1, 1'b0);
    end
  end

  task automatic check_all_low(input int sc);
    check("rst_btn_level",     sc, 0, lvl0, 1'b0);
    check("rst_press",         sc, 0, prs0, 1'b0);
    check("rst_release",       sc, 0, rel0, 1'b0);
    check("rst_repeat",        sc, 0, rep0, 1'b0);
    check("rst_norep_level",   sc, 0, lvl1, 1'b0);
    check("rst_norep_press",   sc, 0, prs1, 1'b0);
    check("rst_norep_release", sc, 0, rel1, 1'b0);
    check("rst_norep_repeat",  sc, 0, rep1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    btn_sync = 1'b0;
    repeat (3) @(negedge clk);
    check_all_low(0);
    rst_n = 1'b1;

    // Three high samples only: never accepted.
    run(1, "0111000", "0000000", "0000000", "0000000", "0000000");
    // Bouncy press 1,1,0,1,1,1,1 then a clean release.
    run(2, "11011110000", "00000011110", "00000010000", "00000000001", "00000000000");
    // Clean press, then hold: repeats at +10, +13, +16, +19 after press.
    run(3, "1111", "0001", "0001", "0000", "0000");
    run(4, "1111111111111111111", "1111111111111111111", "0000000000000000000",
           "0000000000000000000", "0000000001001001001");
    // Release bounce mid-repeat: repeat slips by the two non-held edges.
    run(5, "10111", "11111", "00000", "00000", "00001");
    // Release with bounce 0,0,1,0,0,0,0.
    run(6, "001000000", "111111000", "000000000", "000000100", "000000000");
    // Press and hold into the repeat phase, then reset asynchronously.
    run(7, "1111", "0001", "0001", "0000", "0000");
    run(8, "11111111111", "11111111111", "00000000000", "00000000000", "00000000010");

    #2;
    rst_n = 1'b0;
    #1;
    check_all_low(10);
    btn_sync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Fresh debounce after reset with the button still held.
    run(9, "11110000", "00011110", "00010000", "00000001", "00000000");

    @(negedge clk);
    check("queue_drained", 11, 0, (exp_q.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
